// File: rtl/neuron_update_engine_if.sv
// neuron_update_engine_if: update request/response handshake bundle for neuron_update_engine.
interface neuron_update_engine_if #(
  parameter int DATA_W = 32,
  parameter int ID_W = 4
);
  logic in_valid, in_ready, out_valid, out_ready, out_spike;
  logic [ID_W-1:0] in_id, out_id;
  logic [DATA_W-1:0] in_weight, out_potential;
  modport master(
    output in_valid, in_id, in_weight, out_ready,
    input in_ready, out_valid, out_id, out_potential, out_spike
  );
  modport slave(
    input in_valid, in_id, in_weight, out_ready,
    output in_ready, out_valid, out_id, out_potential, out_spike
  );
endinterface

// File: rtl/neuron_update_engine.sv
// neuron_update_engine: LIF/Izhikevich neuron state update, one update in flight.
// Define NEURON_SAT_EN to saturate adds, subtracts and truncated products instead of wrapping.
module neuron_update_engine #(
  parameter int DATA_W = 32,
  parameter int N_NEURONS = 16,
  parameter int FRAC_W = 16,
  parameter int LEAK_SHIFT = 4,
  localparam int ID_W = $clog2(N_NEURONS)
) (
  input logic clk,
  input logic rst_n,
  input logic [1:0] model,
  input logic cfg_we,
  input logic [2:0] cfg_sel,
  input logic [ID_W-1:0] cfg_id,
  input logic [DATA_W-1:0] cfg_data,
  neuron_update_engine_if.slave io,
  output logic busy
);
  typedef logic signed [DATA_W-1:0] word_t;
  typedef logic signed [2*DATA_W-1:0] wide_t;
  typedef enum logic [2:0] {IDLE, LOAD, MUL_BV, MUL_A, EVAL, RESP} state_t;
  function automatic wide_t sx(input word_t a);
    return {{DATA_W{a[DATA_W-1]}}, a};
  endfunction
  function automatic word_t fit(input wide_t x);
`ifdef NEURON_SAT_EN
    wide_t mx, mn;
    mx = wide_t'({1'b0, {(DATA_W-1){1'b1}}});
    mn = ~mx;
    return x > mx ? word_t'(mx) : x < mn ? word_t'(mn) : word_t'(x);
`else
    return word_t'(x);
`endif
  endfunction
  function automatic word_t add(input word_t a, input word_t b);
    return fit(sx(a) + sx(b));
  endfunction
  function automatic word_t sub(input word_t a, input word_t b);
    return fit(sx(a) - sx(b));
  endfunction
  function automatic word_t mulq(input word_t a, input word_t b);
    wide_t p;
    p = sx(a) * sx(b);
    return fit(p >>> FRAC_W);
  endfunction
  state_t state_q, state_d;
  word_t a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d, vt_q, vt_d;
  word_t v_q [N_NEURONS];
  word_t v_d [N_NEURONS];
  word_t u_q [N_NEURONS];
  word_t u_d [N_NEURONS];
  logic izhi_q, izhi_d, spk_q, spk_d;
  logic [ID_W-1:0] id_q, id_d, oid_q, oid_d;
  word_t w_q, w_d, vr_q, vr_d, ur_q, ur_d, bv_q, bv_d, ut_q, ut_d, pot_q, pot_d;
  word_t vn, v_next, u_next;
  logic spike, cw;
  assign io.in_ready = rst_n && state_q == IDLE && !cfg_we;
  assign io.out_valid = state_q == RESP;
  assign io.out_id = oid_q;
  assign io.out_potential = pot_q;
  assign io.out_spike = spk_q;
  assign busy = state_q != IDLE;
  always_comb begin
    vn = izhi_q ? sub(add(vr_q, w_q), ur_q) : add(sub(vr_q, vr_q >>> LEAK_SHIFT), w_q);
    spike = vn > vt_q;
    v_next = spike ? (izhi_q ? c_q : sub(vn, vt_q)) : vn;
    u_next = izhi_q ? (spike ? add(ur_q, d_q) : ut_q) : ur_q;
  end
  always_comb begin
    cw = cfg_we && state_q == IDLE;
    a_d = (cw && cfg_sel == 3'd0) ? cfg_data : a_q;
    b_d = (cw && cfg_sel == 3'd1) ? cfg_data : b_q;
    c_d = (cw && cfg_sel == 3'd2) ? cfg_data : c_q;
    d_d = (cw && cfg_sel == 3'd3) ? cfg_data : d_q;
    vt_d = (cw && cfg_sel == 3'd4) ? cfg_data : vt_q;
    v_d = v_q;
    u_d = u_q;
    state_d = state_q;
    izhi_d = izhi_q;
    id_d = id_q;
    w_d = w_q;
    vr_d = vr_q;
    ur_d = ur_q;
    bv_d = bv_q;
    ut_d = ut_q;
    oid_d = oid_q;
    pot_d = pot_q;
    spk_d = spk_q;
    if (cw && cfg_sel == 3'd5 && int'(cfg_id) < N_NEURONS) v_d[cfg_id] = cfg_data;
    if (cw && cfg_sel == 3'd6 && int'(cfg_id) < N_NEURONS) u_d[cfg_id] = cfg_data;
    case (state_q)
      IDLE: if (io.in_valid && io.in_ready && int'(io.in_id) < N_NEURONS) begin
        izhi_d = model == 2'b01;
        id_d = io.in_id;
        w_d = io.in_weight;
        state_d = LOAD;
      end
      LOAD: begin
        vr_d = v_q[id_q];
        ur_d = u_q[id_q];
        state_d = izhi_q ? MUL_BV : EVAL;
      end
      MUL_BV: begin
        bv_d = mulq(b_q, vr_q);
        state_d = MUL_A;
      end
      MUL_A: begin
        ut_d = add(ur_q, mulq(a_q, sub(bv_q, ur_q)));
        state_d = EVAL;
      end
      EVAL: begin
        v_d[id_q] = v_next;
        u_d[id_q] = u_next;
        oid_d = id_q;
        pot_d = v_next;
        spk_d = spike;
        state_d = RESP;
      end
      RESP: state_d = io.out_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      d_q <= '0;
      vt_q <= '0;
      v_q <= '{default: '0};
      u_q <= '{default: '0};
      izhi_q <= 1'b0;
      id_q <= '0;
      w_q <= '0;
      vr_q <= '0;
      ur_q <= '0;
      bv_q <= '0;
      ut_q <= '0;
      oid_q <= '0;
      pot_q <= '0;
      spk_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      d_q <= d_d;
      vt_q <= vt_d;
      v_q <= v_d;
      u_q <= u_d;
      izhi_q <= izhi_d;
      id_q <= id_d;
      w_q <= w_d;
      vr_q <= vr_d;
      ur_q <= ur_d;
      bv_q <= bv_d;
      ut_q <= ut_d;
      oid_q <= oid_d;
      pot_q <= pot_d;
      spk_q <= spk_d;
    end
  end
endmodule

// File: tb/tb_neuron_update_engine.sv
// tb_neuron_update_engine: directed scoreboard bench for neuron_update_engine.
module tb_neuron_update_engine;
  localparam int DW = 32;
  localparam int NN = 16;
  localparam int IW = 4;
  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] pot;
    logic spk;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [1:0] model = 2'b00;
  logic cfg_we = 1'b0;
  logic [2:0] cfg_sel = '0;
  logic [IW-1:0] cfg_id = '0;
  logic [DW-1:0] cfg_data = '0;
  logic busy;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  longint mv[NN];
  longint mu[NN];
  longint ma, mb, mc, md, mvt;
  logic [DW-1:0] last_pot;
  logic last_spk;
  neuron_update_engine_if #(.DATA_W(DW), .ID_W(IW)) io();
  neuron_update_engine #(.DATA_W(DW), .N_NEURONS(NN), .FRAC_W(16), .LEAK_SHIFT(4)) dut (
    .clk(clk), .rst_n(rst_n), .model(model), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_id(cfg_id), .cfg_data(cfg_data), .io(io), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic longint f(input longint x);
`ifdef NEURON_SAT_EN
    return x > 64'sd2147483647 ? 64'sd2147483647 : x < -64'sd2147483648 ? -64'sd2147483648 : x;
`else
    logic [31:0] t;
    t = x[31:0];
    return longint'($signed(t));
`endif
  endfunction
  function automatic longint sv(input logic [31:0] d);
    return longint'($signed(d));
  endfunction
  task automatic rst_model();
    foreach (mv[i]) begin
      mv[i] = 0;
      mu[i] = 0;
    end
    ma = 0; mb = 0; mc = 0; md = 0; mvt = 0;
  endtask
  task automatic predict(input int id, input logic [31:0] w, input logic izhi,
                         output logic [31:0] pot, output logic spk);
    longint v, u, ww, vn, bv, ut;
    v = mv[id];
    u = mu[id];
    ww = sv(w);
    if (!izhi) begin
      vn = f(f(v - (v >>> 4)) + ww);
      spk = vn > mvt;
      mv[id] = spk ? f(vn - mvt) : vn;
    end else begin
      bv = f((mb * v) >>> 16);
      ut = f(u + f((ma * f(bv - u)) >>> 16));
      vn = f(f(v + ww) - u);
      spk = vn > mvt;
      mv[id] = spk ? mc : vn;
      mu[id] = spk ? f(u + md) : ut;
    end
    v = mv[id];
    pot = v[31:0];
  endtask
  task automatic cfg(input logic [2:0] sel, input int id, input logic [31:0] d);
    cfg_we = 1'b1;
    cfg_sel = sel;
    cfg_id = IW'(id);
    cfg_data = d;
    case (sel)
      3'd0: ma = sv(d);
      3'd1: mb = sv(d);
      3'd2: mc = sv(d);
      3'd3: md = sv(d);
      3'd4: mvt = sv(d);
      3'd5: mv[id] = sv(d);
      3'd6: mu[id] = sv(d);
      default: ;
    endcase
    @(negedge clk);
    cfg_we = 1'b0;
  endtask
  task automatic send_req(input int id, input logic [31:0] w, input logic [1:0] mdl);
    exp_t e;
    model = mdl;
    io.in_valid = 1'b1;
    io.in_id = IW'(id);
    io.in_weight = w;
    #1;
    chk("in_ready_idle", io.in_ready, 1);
    e.id = IW'(id);
    predict(id, w, mdl == 2'b01, e.pot, e.spk);
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    io.in_valid = 1'b0;
    chk("in_ready_busy", io.in_ready, 0);
  endtask
  task automatic wait_resp(input int exp_lat, input int hold, input logic poke);
    int lat;
    exp_t e;
    lat = 0;
    while (!io.out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
      cfg_we = poke && lat == 1;
      if (cfg_we) begin
        cfg_sel = 3'd4;
        cfg_data = 32'd5;
      end
    end
    cfg_we = 1'b0;
    chk("latency", lat, exp_lat);
    e = q.size() > 0 ? q.pop_front() : '{id: '0, pot: '0, spk: 1'b0};
    for (int i = 0; i <= hold; i++) begin
      chk("out_valid", io.out_valid, 1);
      chk("out_id", io.out_id, e.id);
      chk("out_potential", io.out_potential, e.pot);
      chk("out_spike", io.out_spike, e.spk);
      if (i < hold) begin
        chk("in_ready_resp", io.in_ready, 0);
        @(negedge clk);
      end
    end
    last_pot = io.out_potential;
    last_spk = io.out_spike;
    io.out_ready = 1'b1;
    @(negedge clk);
    io.out_ready = 1'b0;
    #1;
    chk("in_ready_after", io.in_ready, 1);
    chk("busy_idle", busy, 0);
  endtask
  initial begin
    logic seen;
    io.in_valid = 1'b0;
    io.in_id = '0;
    io.in_weight = '0;
    io.out_ready = 1'b0;
    rst_model();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", io.in_ready, 0);
    chk("rst_outputs", {io.out_id, io.out_potential, io.out_spike}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_release", io.in_ready, 1);
    // LIF accumulate, then threshold crossing with 5 cycles of backpressure
    cfg(3'd4, 0, 32'd100);
    send_req(3, 32'd60, 2'b00);
    wait_resp(2, 0, 1'b0);
    chk("lif1_pot", last_pot, 60);
    chk("lif1_spk", last_spk, 0);
    send_req(3, 32'd60, 2'b00);
    wait_resp(2, 5, 1'b0);
    chk("lif2_pot", last_pot, 17);
    chk("lif2_spk", last_spk, 1);
    // Izhikevich spike with Q16 parameters
    cfg(3'd0, 0, 32'h0000_1000);
    cfg(3'd1, 0, 32'h0000_4000);
    cfg(3'd2, 0, 32'hFFBF_0000);
    cfg(3'd3, 0, 32'h0008_0000);
    cfg(3'd4, 0, 32'h001E_0000);
    cfg(3'd5, 0, 32'hFFBF_0000);
    cfg(3'd6, 0, 32'h0000_0000);
    send_req(0, 32'h0064_0000, 2'b01);
    wait_resp(4, 0, 1'b0);
    chk("izhi_pot", last_pot, 32'hFFBF_0000);
    chk("izhi_spk", last_spk, 1);
    // with a=0 and w=0 the potential exposes v-u, revealing u[0]=d
    cfg(3'd0, 0, 32'h0);
    cfg(3'd4, 0, 32'h7FFF_FFFF);
    send_req(0, 32'h0, 2'b01);
    wait_resp(4, 0, 1'b0);
    chk("izhi_u_pot", last_pot, 32'hFFB7_0000);
    chk("izhi_u_spk", last_spk, 0);
    send_req(3, 32'h0, 2'b11);
    wait_resp(2, 0, 1'b0);
    chk("model11_pot", last_pot, 16);
    // overflow
    cfg(3'd5, 7, 32'h7FFF_FF00);
    send_req(7, 32'h7FFF_FFFF, 2'b00);
    wait_resp(2, 0, 1'b0);
`ifdef NEURON_SAT_EN
    chk("ovf_pot", last_pot, 32'h7FFF_FFFF);
`else
    chk("ovf_pot", last_pot, 32'hF7FF_FF0F);
`endif
    chk("ovf_spk", last_spk, 0);
    // vt write attempted during EVAL must not land
    send_req(9, 32'd50, 2'b00);
    wait_resp(2, 0, 1'b1);
    send_req(10, 32'd50, 2'b00);
    wait_resp(2, 0, 1'b0);
    chk("ignored_cfg_pot", last_pot, 50);
    chk("ignored_cfg_spk", last_spk, 0);
    // config write and request in the same IDLE cycle
    cfg_we = 1'b1;
    cfg_sel = 3'd4;
    cfg_data = 32'd10;
    model = 2'b00;
    io.in_valid = 1'b1;
    io.in_id = 4'd5;
    io.in_weight = 32'd20;
    #1;
    chk("in_ready_cfg", io.in_ready, 0);
    mvt = 10;
    @(negedge clk);
    cfg_we = 1'b0;
    send_req(5, 32'd20, 2'b00);
    wait_resp(2, 0, 1'b0);
    chk("cfg_first_pot", last_pot, 10);
    chk("cfg_first_spk", last_spk, 1);
    // reset asserted in MUL_A aborts the update
    send_req(0, 32'h0001_0000, 2'b01);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", io.out_valid, 0);
    chk("abort_in_ready", io.in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_in_ready_release", io.in_ready, 1);
    q.delete();
    rst_model();
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | io.out_valid;
    end
    chk("abort_no_out_valid", seen, 0);
    send_req(0, 32'h0, 2'b00);
    wait_resp(2, 0, 1'b0);
    chk("abort_v0_pot", last_pot, 0);
    chk("abort_v0_spk", last_spk, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
